// File: rtl/writeback_queue.sv
// Write-back queue feeding the register file write port: merges ALU results and in-order load
// returns into a FIFO, drains one write per cycle, and exports a pending-write busy mask.
// Optional WB_BYPASS_EN adds combinational forwarding of the youngest queued value for fwd_addr.
module writeback_queue #(
    parameter int WIDTH         = 16,
    parameter int REGISTER_BITS = 4,
    parameter int DEPTH         = 4,
    parameter int LD_DEPTH      = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            alu_valid,
    output logic                            alu_ready,
    input  logic [REGISTER_BITS-1:0]        alu_addr,
    input  logic [WIDTH-1:0]                alu_data,
    input  logic                            ld_issue,
    output logic                            ld_issue_ready,
    input  logic [REGISTER_BITS-1:0]        ld_issue_addr,
    input  logic                            ld_valid,
    output logic                            ld_ready,
    input  logic [WIDTH-1:0]                ld_data,
    input  logic                            wb_hold,
    output logic                            shouldWrite,
    output logic [REGISTER_BITS-1:0]        writeAddress,
    output logic [WIDTH-1:0]                writeData,
    output logic [(1<<REGISTER_BITS)-1:0]   busy_mask,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            protocol_err,
    input  logic [REGISTER_BITS-1:0]        fwd_addr,
    output logic                            fwd_hit,
    output logic [WIDTH-1:0]                fwd_data
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int LPW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int LCW = $clog2(LD_DEPTH) + 1;
    localparam logic [CW-1:0]  FIFO_FULL = CW'(DEPTH);
    localparam logic [LCW-1:0] TAG_FULL  = LCW'(LD_DEPTH);

    logic [REGISTER_BITS-1:0] fifo_addr [DEPTH];
    logic [WIDTH-1:0]         fifo_data [DEPTH];
    logic [PW-1:0]            fifo_head, fifo_tail;
    logic [CW-1:0]            fifo_cnt;

    logic [REGISTER_BITS-1:0] tag_addr [LD_DEPTH];
    logic [LPW-1:0]           tag_head, tag_tail;
    logic [LCW-1:0]           tag_cnt;

    logic                     fifo_empty, fifo_full, tag_empty, tag_full;
    logic                     ld_acc, alu_acc, tag_push, push;
    logic [REGISTER_BITS-1:0] push_addr;
    logic [WIDTH-1:0]         push_data;

    // Tag queue depth need not fill its pointer range, so wrap explicitly.
    function automatic logic [LPW-1:0] tag_next(input logic [LPW-1:0] p);
        if (p == LPW'(LD_DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    function automatic logic [LPW-1:0] tag_offset(input logic [LPW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= LD_DEPTH) s = s - LD_DEPTH;
        return LPW'(s);
    endfunction

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FIFO_FULL);
    assign tag_empty  = (tag_cnt == '0);
    assign tag_full   = (tag_cnt == TAG_FULL);

    // Load returns win the single push slot; r0 destinations are consumed but never queued.
    assign ld_ready       = !fifo_full && !tag_empty;
    assign ld_acc         = ld_valid && ld_ready;
    assign alu_ready      = !fifo_full && !ld_acc;
    assign alu_acc        = alu_valid && alu_ready;
    assign ld_issue_ready = !tag_full || ld_acc;
    assign tag_push       = ld_issue && ld_issue_ready;
    assign push_addr      = ld_acc ? tag_addr[tag_head] : alu_addr;
    assign push_data      = ld_acc ? ld_data : alu_data;
    assign push           = (ld_acc || alu_acc) && (push_addr != '0);

    assign shouldWrite  = !fifo_empty && !wb_hold && !reset;
    assign writeAddress = fifo_empty ? '0 : fifo_addr[fifo_head];
    assign writeData    = fifo_empty ? '0 : fifo_data[fifo_head];
    assign count        = fifo_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            fifo_head    <= '0;
            fifo_tail    <= '0;
            fifo_cnt     <= '0;
            tag_head     <= '0;
            tag_tail     <= '0;
            tag_cnt      <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (push) fifo_tail <= fifo_tail + 1'b1;
            if (shouldWrite) fifo_head <= fifo_head + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(shouldWrite);
            if (tag_push) tag_tail <= tag_next(tag_tail);
            if (ld_acc) tag_head <= tag_next(tag_head);
            tag_cnt <= tag_cnt + LCW'(tag_push) - LCW'(ld_acc);
            if (ld_valid && tag_empty) protocol_err <= 1'b1;
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[fifo_tail] <= push_addr;
            fifo_data[fifo_tail] <= push_data;
        end
        if (tag_push) tag_addr[tag_tail] <= ld_issue_addr;
    end

    always_comb begin
        busy_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < fifo_cnt) busy_mask[fifo_addr[fifo_head + PW'(k)]] = 1'b1;
        end
        for (int k = 0; k < LD_DEPTH; k++) begin
            if (LCW'(k) < tag_cnt) busy_mask[tag_addr[tag_offset(tag_head, k)]] = 1'b1;
        end
        busy_mask[0] = 1'b0;
    end

`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < fifo_cnt) && (fwd_addr != '0) &&
                (fifo_addr[fifo_head + PW'(k)] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data[fifo_head + PW'(k)];
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_addr;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus a randomized run
// compared every cycle against a queue-based reference model.
module tb_writeback_queue;

    localparam int WIDTH = 16;
    localparam int RB = 4;
    localparam int DEPTH = 4;
    localparam int LD_DEPTH = 2;

    logic clock = 1'b0;
    logic reset;
    logic alu_valid, alu_ready;
    logic [RB-1:0] alu_addr;
    logic [WIDTH-1:0] alu_data;
    logic ld_issue, ld_issue_ready;
    logic [RB-1:0] ld_issue_addr;
    logic ld_valid, ld_ready;
    logic [WIDTH-1:0] ld_data;
    logic wb_hold, shouldWrite;
    logic [RB-1:0] writeAddress;
    logic [WIDTH-1:0] writeData;
    logic [15:0] busy_mask;
    logic [2:0] count;
    logic protocol_err;
    logic [RB-1:0] fwd_addr;
    logic fwd_hit;
    logic [WIDTH-1:0] fwd_data;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [RB-1:0]    a;
        logic [WIDTH-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic [RB-1:0] mt[$];
    logic          mperr;

    always #5 clock = ~clock;

    writeback_queue #(.WIDTH(WIDTH), .REGISTER_BITS(RB), .DEPTH(DEPTH), .LD_DEPTH(LD_DEPTH)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_ready(ld_issue_ready), .ld_issue_addr(ld_issue_addr),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .wb_hold(wb_hold), .shouldWrite(shouldWrite), .writeAddress(writeAddress),
        .writeData(writeData), .busy_mask(busy_mask), .count(count),
        .protocol_err(protocol_err), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    task automatic idle();
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        ld_issue = 0; ld_issue_addr = 0; ld_valid = 0; ld_data = 0;
        wb_hold = 0; fwd_addr = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        @(negedge clock);
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (shouldWrite !== 1'b0) begin n_fail++; $display("FAIL reset_shouldWrite got %b want 0", shouldWrite); end
        n_checks++; if (writeAddress !== 4'd0 || writeData !== 16'd0) begin n_fail++; $display("FAIL reset_port got %h/%h want 0/0", writeAddress, writeData); end
        n_checks++; if (busy_mask !== 16'd0) begin n_fail++; $display("FAIL reset_busy got %h want 0", busy_mask); end
        n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b want 0", protocol_err); end
        n_checks++; if ({alu_ready, ld_ready, ld_issue_ready} !== 3'b101) begin n_fail++; $display("FAIL reset_ready got %b want 101", {alu_ready, ld_ready, ld_issue_ready}); end
        tick();
    endtask

    task automatic test_single_alu();
        alu_valid = 1; alu_addr = 3; alu_data = 16'h1234;
        tick();
        alu_valid = 0;
        @(negedge clock);
        n_checks++; if ({shouldWrite, writeAddress, writeData} !== {1'b1, 4'd3, 16'h1234}) begin n_fail++; $display("FAIL single_write got %b/%0d/%h want 1/3/1234", shouldWrite, writeAddress, writeData); end
        n_checks++; if (busy_mask[3] !== 1'b1) begin n_fail++; $display("FAIL single_busy got %h want bit3", busy_mask); end
        tick();
        @(negedge clock);
        n_checks++; if (shouldWrite !== 1'b0 || busy_mask !== 16'd0 || count !== 3'd0) begin n_fail++; $display("FAIL single_after got sw=%b busy=%h cnt=%0d want 0/0/0", shouldWrite, busy_mask, count); end
        tick();
    endtask

    task automatic test_fill_hold();
        wb_hold = 1;
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1; alu_addr = RB'(i); alu_data = 16'(8'h11 * i);
            tick();
        end
        alu_valid = 0;
        @(negedge clock);
        n_checks++; if (count !== 3'd4 || alu_ready !== 1'b0 || shouldWrite !== 1'b0) begin n_fail++; $display("FAIL fill_state got cnt=%0d ar=%b sw=%b want 4/0/0", count, alu_ready, shouldWrite); end
        n_checks++; if (busy_mask !== 16'h001E) begin n_fail++; $display("FAIL fill_busy got %h want 001e", busy_mask); end
        tick();
        wb_hold = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            n_checks++; if ({shouldWrite, writeAddress, writeData} !== {1'b1, RB'(i), 16'(8'h11 * i)}) begin n_fail++; $display("FAIL drain_%0d got %b/%0d/%h want 1/%0d/%h", i, shouldWrite, writeAddress, writeData, i, 16'(8'h11 * i)); end
            tick();
        end
        @(negedge clock);
        n_checks++; if (count !== 3'd0 || shouldWrite !== 1'b0) begin n_fail++; $display("FAIL drain_done got cnt=%0d sw=%b want 0/0", count, shouldWrite); end
        tick();
    endtask

    task automatic test_load_priority();
        ld_issue = 1; ld_issue_addr = 5;
        tick();
        ld_issue = 0;
        ld_valid = 1; ld_data = 16'hBEEF;
        alu_valid = 1; alu_addr = 6; alu_data = 16'h0006;
        @(negedge clock);
        n_checks++; if (busy_mask[5] !== 1'b1) begin n_fail++; $display("FAIL ld_busy_issue got %h want bit5", busy_mask); end
        n_checks++; if (ld_ready !== 1'b1 || alu_ready !== 1'b0) begin n_fail++; $display("FAIL ld_prio got lr=%b ar=%b want 1/0", ld_ready, alu_ready); end
        tick();
        ld_valid = 0;
        @(negedge clock);
        n_checks++; if ({shouldWrite, writeAddress, writeData} !== {1'b1, 4'd5, 16'hBEEF}) begin n_fail++; $display("FAIL ld_write got %b/%0d/%h want 1/5/beef", shouldWrite, writeAddress, writeData); end
        n_checks++; if (busy_mask[5] !== 1'b1 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL ld_busy_q got %h ar=%b want bit5/1", busy_mask, alu_ready); end
        tick();
        alu_valid = 0;
        @(negedge clock);
        n_checks++; if ({shouldWrite, writeAddress, writeData} !== {1'b1, 4'd6, 16'h0006}) begin n_fail++; $display("FAIL alu_after_ld got %b/%0d/%h want 1/6/0006", shouldWrite, writeAddress, writeData); end
        n_checks++; if (busy_mask !== 16'h0040) begin n_fail++; $display("FAIL ld_busy_clear got %h want 0040", busy_mask); end
        tick();
    endtask

    task automatic test_r0_error();
        alu_valid = 1; alu_addr = 0; alu_data = 16'hFFFF;
        @(negedge clock);
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready got %b want 1", alu_ready); end
        tick();
        alu_valid = 0;
        @(negedge clock);
        n_checks++; if (count !== 3'd0 || shouldWrite !== 1'b0) begin n_fail++; $display("FAIL r0_drop got cnt=%0d sw=%b want 0/0", count, shouldWrite); end
        ld_valid = 1; ld_data = 16'h5555;
        @(negedge clock);
        n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL orphan_ready got %b want 0", ld_ready); end
        tick();
        ld_valid = 0;
        tick(); tick();
        @(negedge clock);
        n_checks++; if (protocol_err !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL perr_sticky got perr=%b cnt=%0d want 1/0", protocol_err, count); end
        reset = 1;
        tick();
        reset = 0;
        @(negedge clock);
        n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL perr_clear got %b want 0", protocol_err); end
        tick();
    endtask

    task automatic test_reset_mid();
        wb_hold = 1;
        for (int i = 1; i <= 3; i++) begin
            alu_valid = 1; alu_addr = RB'(i); alu_data = 16'(i);
            tick();
        end
        alu_valid = 0;
        ld_issue = 1; ld_issue_addr = 9;
        tick();
        ld_issue = 0;
        @(negedge clock);
        n_checks++; if (count !== 3'd3 || busy_mask !== 16'h020E) begin n_fail++; $display("FAIL mid_before got cnt=%0d busy=%h want 3/020e", count, busy_mask); end
        reset = 1; wb_hold = 0;
        @(negedge clock);
        n_checks++; if (shouldWrite !== 1'b0) begin n_fail++; $display("FAIL mid_in_reset got sw=%b want 0", shouldWrite); end
        tick();
        reset = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_checks++; if (count !== 3'd0 || busy_mask !== 16'd0 || shouldWrite !== 1'b0) begin n_fail++; $display("FAIL mid_after_%0d got cnt=%0d busy=%h sw=%b want 0/0/0", c, count, busy_mask, shouldWrite); end
            tick();
        end
    endtask

    task automatic test_bypass();
        logic       exp_hit;
        logic [15:0] exp_data;
`ifdef WB_BYPASS_EN
        exp_hit = 1'b1; exp_data = 16'h000B;
`else
        exp_hit = 1'b0; exp_data = 16'h0000;
`endif
        wb_hold = 1;
        alu_valid = 1; alu_addr = 7; alu_data = 16'h000A;
        tick();
        alu_data = 16'h000B;
        tick();
        alu_valid = 0; fwd_addr = 7;
        @(negedge clock);
        n_checks++; if (fwd_hit !== exp_hit || fwd_data !== exp_data) begin n_fail++; $display("FAIL fwd_r7 got %b/%h want %b/%h", fwd_hit, fwd_data, exp_hit, exp_data); end
        fwd_addr = 0;
        @(negedge clock);
        n_checks++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0) begin n_fail++; $display("FAIL fwd_r0 got %b/%h want 0/0000", fwd_hit, fwd_data); end
        tick();
        wb_hold = 0;
        tick(); tick();
    endtask

    task automatic test_random(int ncyc);
        logic        e_full, e_lr, e_ar, e_ir, e_sw, e_hit;
        logic [RB-1:0]    e_wa, pa;
        logic [WIDTH-1:0] e_wd, e_fd;
        logic [15:0] e_busy;
        for (int c = 0; c < ncyc; c++) begin
            reset     = (c == 0) || ($urandom_range(0, 149) == 0);
            alu_valid = $urandom_range(0, 1);
            alu_addr  = RB'($urandom_range(0, 15));
            alu_data  = WIDTH'($urandom);
            ld_issue  = $urandom_range(0, 2) == 0;
            ld_issue_addr = RB'($urandom_range(0, 15));
            ld_valid  = (mt.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
            ld_data   = WIDTH'($urandom);
            wb_hold   = $urandom_range(0, 2) == 0;
            fwd_addr  = RB'($urandom_range(0, 15));
            @(negedge clock);
            e_full = (mq.size() == DEPTH);
            e_lr   = !e_full && (mt.size() > 0);
            e_ar   = !e_full && !(ld_valid && e_lr);
            e_ir   = (mt.size() < LD_DEPTH) || (ld_valid && e_lr);
            e_sw   = (mq.size() > 0) && !wb_hold && !reset;
            e_wa   = (mq.size() > 0) ? mq[0].a : '0;
            e_wd   = (mq.size() > 0) ? mq[0].d : '0;
            e_busy = '0;
            foreach (mq[i]) e_busy[mq[i].a] = 1'b1;
            foreach (mt[i]) e_busy[mt[i]] = 1'b1;
            e_busy[0] = 1'b0;
            e_hit = 1'b0; e_fd = '0;
`ifdef WB_BYPASS_EN
            if (fwd_addr != 0) foreach (mq[i]) if (mq[i].a == fwd_addr) begin e_hit = 1'b1; e_fd = mq[i].d; end
`endif
            n_checks++; if ({alu_ready, ld_ready, ld_issue_ready} !== {e_ar, e_lr, e_ir}) begin n_fail++; $display("FAIL rnd_ready c%0d got %b want %b", c, {alu_ready, ld_ready, ld_issue_ready}, {e_ar, e_lr, e_ir}); end
            n_checks++; if ({shouldWrite, writeAddress, writeData} !== {e_sw, e_wa, e_wd}) begin n_fail++; $display("FAIL rnd_port c%0d got %b/%0d/%h want %b/%0d/%h", c, shouldWrite, writeAddress, writeData, e_sw, e_wa, e_wd); end
            n_checks++; if (count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_count c%0d got %0d want %0d", c, count, mq.size()); end
            n_checks++; if (busy_mask !== e_busy) begin n_fail++; $display("FAIL rnd_busy c%0d got %h want %h", c, busy_mask, e_busy); end
            n_checks++; if (protocol_err !== mperr) begin n_fail++; $display("FAIL rnd_perr c%0d got %b want %b", c, protocol_err, mperr); end
            n_checks++; if ({fwd_hit, fwd_data} !== {e_hit, e_fd}) begin n_fail++; $display("FAIL rnd_fwd c%0d got %b/%h want %b/%h", c, fwd_hit, fwd_data, e_hit, e_fd); end
            @(posedge clock);
            if (reset) begin
                mq.delete(); mt.delete(); mperr = 1'b0;
            end else begin
                if (ld_valid && mt.size() == 0) mperr = 1'b1;
                if (e_sw) void'(mq.pop_front());
                if (ld_valid && e_lr) begin
                    pa = mt.pop_front();
                    if (pa != 0) mq.push_back('{a: pa, d: ld_data});
                end else if (alu_valid && e_ar && alu_addr != 0) begin
                    mq.push_back('{a: alu_addr, d: alu_data});
                end
                if (ld_issue && e_ir) mt.push_back(ld_issue_addr);
            end
            #1;
        end
        reset = 0;
        idle();
    endtask

    initial begin
        mperr = 1'b0;
        reset = 1'b1;
        idle();
        test_reset();
        test_single_alu();
        test_fill_hold();
        test_load_priority();
        test_r0_error();
        test_reset_mid();
        test_bypass();
        test_random(3000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
